// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message schedule, loads 16 words then streams W0..W63 with K_t.
// Define SHA256_SCHED_KROM_EN to drive OUT_K from the round-constant table; otherwise OUT_K is 0.
module sha256_msg_sched (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_W,
  output logic [31:0] OUT_K,
  output logic [5:0]  OUT_IDX,
  output logic        OUT_LAST,
  output logic        BUSY
);
  typedef enum logic {LOAD, EXPAND} state_t;
  state_t      r_state, w_state_nx;
  logic [31:0] r_win [16];
  logic [3:0]  r_cnt;
  logic [5:0]  r_idx;
  logic        r_in_ready;
  logic        w_in_hs, w_out_hs;
  logic [31:0] w_new;
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  always_comb begin
    w_in_hs    = (r_state == LOAD) && IN_VALID && r_in_ready;
    w_out_hs   = (r_state == EXPAND) && OUT_READY;
    w_new      = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];
    w_state_nx = (w_in_hs && &r_cnt) ? EXPAND : (w_out_hs && &r_idx) ? LOAD : r_state;
  end
  // cnt and idx wrap to 0 naturally at the end of each phase
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_state    <= LOAD;
      r_in_ready <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= (w_state_nx == LOAD);
      if (w_in_hs) begin
        r_win[r_cnt] <= IN_DATA;
        r_cnt        <= r_cnt + 4'd1;
      end
      if (w_out_hs) begin
        for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
        r_win[15] <= w_new;
        r_idx     <= r_idx + 6'd1;
      end
    end
  end
  assign IN_READY  = r_in_ready;
  assign OUT_VALID = (r_state == EXPAND);
  assign BUSY      = OUT_VALID;
  assign OUT_W     = OUT_VALID ? r_win[0] : '0;
  assign OUT_IDX   = OUT_VALID ? r_idx : '0;
  assign OUT_LAST  = OUT_VALID && &r_idx;
`ifdef SHA256_SCHED_KROM_EN
  localparam logic [31:0] k_rom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign OUT_K = OUT_VALID ? k_rom[r_idx] : '0;
`else
  assign OUT_K = '0;
`endif
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: directed + randomized checks of sha256_msg_sched against an array-based schedule model.
module tb_sha256_msg_sched;
  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN_DATA = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT_W;
  logic [31:0] OUT_K;
  logic [5:0]  OUT_IDX;
  logic        OUT_LAST;
  logic        BUSY;
  int checks = 0;
  int failures = 0;
  logic [31:0] msg [16];
  logic [31:0] exp_w [64];
  sha256_msg_sched dut (
    .ACLK(ACLK), .ARST(ARST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_W(OUT_W), .OUT_K(OUT_K),
    .OUT_IDX(OUT_IDX), .OUT_LAST(OUT_LAST), .BUSY(BUSY)
  );
  always #5 ACLK = ~ACLK;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic build_model();
    for (int t = 0; t < 64; t++)
      if (t < 16) exp_w[t] = msg[t];
      else exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
  endtask
  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_model();
  endtask
  task automatic set_rand();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_model();
  endtask
  task automatic do_reset(input int n);
    ARST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    repeat (n) begin
      @(negedge ACLK);
      chk("rst_in_ready", IN_READY, 0);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_out_w", OUT_W, 0);
      chk("rst_out_k", OUT_K, 0);
      chk("rst_out_idx", OUT_IDX, 0);
      chk("rst_out_last", OUT_LAST, 0);
      chk("rst_busy", BUSY, 0);
    end
    ARST = 1'b0;
    @(negedge ACLK);
    chk("rel_in_ready", IN_READY, 1);
    chk("rel_out_valid", OUT_VALID, 0);
  endtask
  task automatic load_block(input int gap);
    int k = 0;
    int cyc = 0;
    logic v, acc;
    while (k < 16 && cyc < 200) begin
      chk("load_out_valid", OUT_VALID, 0);
      chk("load_in_ready", IN_READY, 1);
      v = gap != 0 ? cyc[0] : 1'b1;
      IN_VALID = v;
      IN_DATA = v ? msg[k] : $urandom;
      OUT_READY = 1'($urandom_range(1));
      acc = v && IN_READY;
      @(negedge ACLK);
      cyc++;
      if (acc) k++;
    end
    IN_VALID = 1'b0;
    chk("load_count", k, 16);
    chk("latency_valid", OUT_VALID, 1);
  endtask
  task automatic expand_block(input int bp, input int abort_at);
    int got = 0;
    int cyc = 0;
    int stalls = 0;
    logic rdy;
    while (got < 64 && cyc < 400) begin
      chk("out_valid", OUT_VALID, 1);
      chk("out_w", OUT_W, exp_w[got]);
      chk("out_idx", OUT_IDX, got);
      chk("out_last", OUT_LAST, got == 63);
      chk("exp_in_ready", IN_READY, 0);
      chk("busy", BUSY, 1);
`ifdef SHA256_SCHED_KROM_EN
      if (got == 0) chk("out_k0", OUT_K, 32'h428a2f98);
      if (got == 63) chk("out_k63", OUT_K, 32'hc67178f2);
`else
      chk("out_k_zero", OUT_K, 0);
`endif
      if (got == abort_at) return;
      rdy = bp == 0 ? 1'b1 : (got == 16 && stalls < 3) ? 1'b0 : (got > 16) ? ($urandom_range(3) != 0) : 1'b1;
      if (got == 16 && !rdy) stalls++;
      OUT_READY = rdy;
      IN_VALID = 1'($urandom_range(1));
      IN_DATA = $urandom;
      @(negedge ACLK);
      cyc++;
      if (rdy) got++;
    end
    IN_VALID = 1'b0;
    chk("expand_count", got, 64);
    chk("post_out_valid", OUT_VALID, 0);
    chk("post_in_ready", IN_READY, 1);
    chk("post_busy", BUSY, 0);
  endtask
  initial begin
    do_reset(2);
    repeat (5) begin
      @(negedge ACLK);
      chk("idle_out_valid", OUT_VALID, 0);
      chk("idle_in_ready", IN_READY, 1);
    end
    set_abc();
    load_block(0);
    expand_block(0, -1);
    load_block(0);
    expand_block(1, -1);
    set_rand();
    load_block(1);
    expand_block(1, -1);
    set_abc();
    load_block(0);
    expand_block(0, 30);
    ARST = 1'b1; OUT_READY = 1'b1;
    @(negedge ACLK);
    chk("abort_out_valid", OUT_VALID, 0);
    chk("abort_in_ready", IN_READY, 0);
    chk("abort_out_w", OUT_W, 0);
    ARST = 1'b0;
    @(negedge ACLK);
    chk("abort_rel_in_ready", IN_READY, 1);
    load_block(0);
    expand_block(0, -1);
    repeat (3) begin
      set_rand();
      load_block(int'($urandom_range(1)));
      expand_block(1, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
